// File: rtl/eth_parser_pkg.sv
// Shared Ethernet parser types: MAC/VLAN typedefs and the per-frame metadata record.
// ETH_META_TIMESTAMP_EN appends a 32-bit ts_start field to the record.
package eth_parser_pkg;

   localparam int META_MAX_VLAN = 2;
   localparam int VLAN_CNT_W    = $clog2(META_MAX_VLAN + 1);

   typedef logic [47:0] mac_addr_t;
   typedef logic [11:0] vlan_id_t;
`ifdef ETH_META_TIMESTAMP_EN
   typedef logic [31:0] ts_t;
`endif

   typedef struct packed {
      mac_addr_t                         dest_mac;
      mac_addr_t                         src_mac;
      logic [VLAN_CNT_W-1:0]             vlan_count;
      vlan_id_t [META_MAX_VLAN-1:0]      vlan_tags;
      logic                              vlan_ovf;
      logic                              is_ipv4;
      logic                              is_ipv6;
      logic                              is_arp;
      logic                              is_unknown;
`ifdef ETH_META_TIMESTAMP_EN
      ts_t                               ts_start;
`endif
   } eth_meta_rec_t;

endpackage

// File: rtl/meta_sync_fifo.sv
// Generic single-clock FIFO with full/empty/level; reads are combinational from the head.
module meta_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign rd_ok   = rd_en && !empty;
   // A write into a full FIFO is legal only when the head leaves in the same cycle.
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/metadata_queue_packager.sv
// Per-frame metadata capture (MACs, stacked VLANs, protocol flags) queued onto a valid/ready stream.
// Optional ETH_META_TIMESTAMP_EN adds a free-running cycle counter latched at frame_start.
module metadata_queue_packager
   import eth_parser_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_VLAN = META_MAX_VLAN,
   parameter int CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start,
   input  logic                    frame_end,
   input  mac_addr_t               dest_mac,
   input  mac_addr_t               src_mac,
   input  logic                    vlan_tag_valid,
   input  vlan_id_t                vlan_tag,
   input  logic                    proto_valid,
   input  logic                    is_ipv4,
   input  logic                    is_ipv6,
   input  logic                    is_arp,
   input  logic                    is_unknown,
   output eth_meta_rec_t           m_metadata,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic [CNT_W-1:0]        abort_cnt
);

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_IN_FRAME = 1'b1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   logic [0:0]                    state_q;
   logic [VLAN_CNT_W-1:0]         vlan_count_q;
   logic                          vlan_ovf_q;
   vlan_id_t [META_MAX_VLAN-1:0]  tags_q;

   logic [VLAN_CNT_W-1:0]         cur_count;
   logic                          cur_ovf;
   vlan_id_t [META_MAX_VLAN-1:0]  cur_tags;

   logic          in_frame;
   logic          single_cycle;
   logic          accept_tag;
   logic          eval_push;
   logic          push;
   logic          pop;
   logic          drop;
   logic          abort;
   logic          fifo_full;
   logic          fifo_empty;
   eth_meta_rec_t rec;

`ifdef ETH_META_TIMESTAMP_EN
   ts_t ts_cnt_q;
   ts_t ts_start_q;
`endif

   assign in_frame     = (state_q == ST_IN_FRAME);
   assign single_cycle = !in_frame && frame_start && frame_end;
   assign accept_tag   = vlan_tag_valid && (in_frame || single_cycle);
   assign eval_push    = frame_end && (in_frame || frame_start);
   assign pop          = m_valid && m_ready;
   assign push         = eval_push && proto_valid && (!fifo_full || pop);
   assign drop         = eval_push && !push;
   assign abort        = in_frame && frame_start && !frame_end;

   // Tag view for the frame being closed, including a tag arriving alongside frame_end.
   always_comb begin
      cur_count = in_frame ? vlan_count_q : '0;
      cur_ovf   = in_frame ? vlan_ovf_q   : 1'b0;
      cur_tags  = in_frame ? tags_q       : '0;
      if (accept_tag) begin
         if (cur_count < VLAN_CNT_W'(MAX_VLAN)) begin
            for (int i = 0; i < META_MAX_VLAN; i++) begin
               if (VLAN_CNT_W'(i) == cur_count) begin
                  cur_tags[i] = vlan_tag;
               end
            end
            cur_count = cur_count + 1'b1;
         end else begin
            cur_ovf = 1'b1;
         end
      end
   end

   always_comb begin
      rec            = '0;
      rec.dest_mac   = dest_mac;
      rec.src_mac    = src_mac;
      rec.vlan_count = cur_count;
      rec.vlan_tags  = cur_tags;
      rec.vlan_ovf   = cur_ovf;
      rec.is_ipv4    = is_ipv4;
      rec.is_ipv6    = is_ipv6;
      rec.is_arp     = is_arp;
      rec.is_unknown = is_unknown;
`ifdef ETH_META_TIMESTAMP_EN
      rec.ts_start   = in_frame ? ts_start_q : ts_cnt_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         vlan_count_q <= '0;
         vlan_ovf_q   <= 1'b0;
         tags_q       <= '0;
         drop_cnt     <= '0;
         abort_cnt    <= '0;
      end else begin
         if (frame_start) begin
            vlan_count_q <= '0;
            vlan_ovf_q   <= 1'b0;
            tags_q       <= '0;
            state_q      <= single_cycle ? ST_IDLE : ST_IN_FRAME;
         end else if (in_frame) begin
            vlan_count_q <= cur_count;
            vlan_ovf_q   <= cur_ovf;
            tags_q       <= cur_tags;
            if (frame_end) begin
               state_q <= ST_IDLE;
            end
         end
         if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
         end
         if (abort) begin
            abort_cnt <= sat_inc(abort_cnt);
         end
      end
   end

`ifdef ETH_META_TIMESTAMP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt_q   <= '0;
         ts_start_q <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 1'b1;
         if (frame_start) begin
            ts_start_q <= ts_cnt_q;
         end
      end
   end
`endif

   meta_sync_fifo #(
      .WIDTH ($bits(eth_meta_rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (rec),
      .rd_en   (m_ready),
      .rd_data (m_metadata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign m_valid = !fifo_empty;

endmodule
